// File: rtl/pc_predict_unit.sv
// rtl/pc_predict_unit.sv - fetch PC register with direct-mapped BTB next-PC prediction
module pc_predict_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BTB_DEPTH = 16,
    localparam int             IDX_W     = $clog2(BTB_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             valid_q [BTB_DEPTH];
    logic [1:0]       ctr_q   [BTB_DEPTH];
    logic [TAG_W-1:0] tag_q   [BTB_DEPTH];
    logic [XLEN-1:0]  tgt_q   [BTB_DEPTH];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, u_hit;
    logic [XLEN-1:0]  pc_plus4;

    assign l_idx    = pc_q[IDX_W+1:2];
    assign l_tag    = pc_q[XLEN-1:IDX_W+2];
    assign u_idx    = upd_pc[IDX_W+1:2];
    assign u_tag    = upd_pc[XLEN-1:IDX_W+2];
    assign l_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign pc_plus4 = pc_q + XLEN'(4);

    assign pc          = pc_q;
    assign pred_taken  = l_hit && ctr_q[l_idx][1];
    assign pred_target = pred_taken ? tgt_q[l_idx] : pc_plus4;

    // A redirect is a flush and must not be swallowed by back-pressure.
    always_comb begin
        pc_d = pred_target;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken && ctr_q[u_idx] != 2'b11) begin
                    ctr_q[u_idx] <= ctr_q[u_idx] + 2'b01;
                end else if (!upd_taken && ctr_q[u_idx] != 2'b00) begin
                    ctr_q[u_idx] <= ctr_q[u_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= 2'b10;
            end
        end
    end

    // Tag and target carry no reset; any taken update (hit or allocate) writes both.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag_q[u_idx] <= u_tag;
            tgt_q[u_idx] <= upd_target;
        end
    end

endmodule

// File: tb/tb_pc_predict_unit.sv
// tb/tb_pc_predict_unit.sv - directed vectors for pc_predict_unit
module tb_pc_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    int total = 0;
    int bad   = 0;

    pc_predict_unit #(.XLEN(32), .RESET_PC(32'h0), .BTB_DEPTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic redir(input logic [31:0] addr);
        redirect_valid = 1'b1;
        redirect_pc    = addr;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic upd(input logic [31:0] a, input logic tk, input logic [31:0] t);
        upd_valid  = 1'b1;
        upd_pc     = a;
        upd_taken  = tk;
        upd_target = t;
        step();
        upd_valid  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_pt", pred_taken, 1'b0);
        check("rst_ptgt", pred_target, 32'h4);
        rst_n = 1'b1;

        step(); check("run_pc4", pc, 32'h4);
        step(); check("run_pc8", pc, 32'h8);
        step(); check("run_pcC", pc, 32'hC); check("run_pt", pred_taken, 1'b0);
        step(); check("run_pc10", pc, 32'h10);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check("stall_hold", pc, 32'h10);
        end
        redir(32'h200); check("redir_over_stall", pc, 32'h200);
        stall = 1'b0;

        // Train 0x40 -> 0x100 in the same cycle as redirecting to 0x40.
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
        redir(32'h40);
        upd_valid = 1'b0;
        check("train_pc", pc, 32'h40);
        check("train_pt", pred_taken, 1'b1);
        check("train_ptgt", pred_target, 32'h100);
        step(); check("train_follow", pc, 32'h100);

        stall = 1'b1;
        upd(32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b0, 32'h0);
        redir(32'h40);
        check("nt_pt", pred_taken, 1'b0);
        check("nt_ptgt", pred_target, 32'h44);
        stall = 1'b0;
        step(); check("nt_follow", pc, 32'h44);
        stall = 1'b1;

        // 0x80 shares index 0 with 0x40; first update allocates at 2'b10.
        for (int i = 0; i < 4; i++) upd(32'h80, 1'b1, 32'h300);
        upd(32'h80, 1'b0, 32'h0);
        redir(32'h80);
        check("sat_pt", pred_taken, 1'b1);
        check("sat_ptgt", pred_target, 32'h300);
        upd(32'h80, 1'b0, 32'h0);
        check("sat_weak_nt", pred_taken, 1'b0);
        redir(32'h40);
        check("evicted_by_80", pred_taken, 1'b0);

        upd(32'h40, 1'b1, 32'h100);
        check("alias_train_pt", pred_taken, 1'b1);
        redir(32'h440);
        check("alias_miss_pt", pred_taken, 1'b0);
        check("alias_miss_ptgt", pred_target, 32'h444);
        upd(32'h440, 1'b1, 32'h500);
        check("alias_new_pt", pred_taken, 1'b1);
        check("alias_new_ptgt", pred_target, 32'h500);
        redir(32'h40);
        check("alias_evict_pt", pred_taken, 1'b0);

        redir(32'hFFFF_FFFC);
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_ptgt", pred_target, 32'h0);
        stall = 1'b0;
        step(); check("wrap_next", pc, 32'h0);
        stall = 1'b1;

        upd_valid = 1'b1; upd_pc = 32'h0; upd_taken = 1'b1; upd_target = 32'h600;
        #1;
        check("same_old_pt", pred_taken, 1'b0);
        check("same_old_ptgt", pred_target, 32'h4);
        step();
        upd_valid = 1'b0;
        check("same_new_pt", pred_taken, 1'b1);
        check("same_new_ptgt", pred_target, 32'h600);
        stall = 1'b0;
        step(); check("same_follow", pc, 32'h600);

        // Asynchronous reset mid-run clears PC and BTB without a clock edge.
        redir(32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_pt", pred_taken, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
- Fetch-stage program-counter unit: holds the architectural fetch PC and chooses the next PC each cycle.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches and jumps are predicted at fetch.
- Execute-stage redirects (mispredict, JALR, trap) override everything; EX trains the BTB with resolved control transfers.

Parameters:
- XLEN, 32, datapath/PC width; legal values 32 or 64.
- RESET_PC, 32'h0000_0000, PC value loaded on reset (XLEN bits, zero-extended).
- BTB_DEPTH, 16, number of BTB entries; power of two, 2..256.
- IDX_W, $clog2(BTB_DEPTH), index width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold the PC (IF/ID back-pressure).
- redirect_valid  input  1  EX redirect: mispredict, JALR or trap.
- redirect_pc  input  XLEN  target of the redirect, already computed by EX (pc+imm or rs1+imm).
- upd_valid  input  1  EX resolved a control-transfer instruction this cycle.
- upd_pc  input  XLEN  PC of the resolved instruction.
- upd_taken  input  1  resolved direction.
- upd_target  input  XLEN  resolved target; meaningful when upd_taken=1.
- pc  output  XLEN  current fetch PC (registered).
- pred_taken  output  1  BTB predicts the instruction at pc is taken.
- pred_target  output  XLEN  predicted next PC: BTB target if pred_taken, else pc+4.

Behaviour:
- Reset, asynchronous on rst_n low:
  - pc = RESET_PC.
  - All BTB valid bits = 0, all counters = 2'b01, tags/targets don't-care.
  - Therefore pred_taken = 0 and pred_target = RESET_PC+4.
  - Reset released mid-operation discards all in-flight state; there are no partial updates.
- Lookup is combinational on pc:
  - idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
  - hit = valid[idx] & (tag_mem[idx] == tag).
  - pred_taken = hit & ctr[idx][1].
  - pred_target = pred_taken ? tgt_mem[idx] : pc+4.
- Next-PC priority, registered at posedge clk:
  1. redirect_valid: pc <= redirect_pc. This wins over stall, because a flush must not be lost.
  2. stall: pc holds.
  3. Otherwise: pc <= pred_target.
- Arithmetic:
  - pc+4 is modulo 2^XLEN (e.g. 32'hFFFF_FFFC -> 32'h0).
  - pc[1:0] is not forced; redirect_pc is taken verbatim.
- BTB update at posedge, when upd_valid=1 (independent of stall/redirect); u_idx and u_tag are derived from upd_pc:
  - Hit, taken: ctr saturating increment (max 2'b11); tgt_mem <= upd_target.
  - Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate/replace: valid=1, tag=u_tag, tgt=upd_target, ctr=2'b10 (weakly taken).
  - Miss, not taken: no change.
- Simultaneous lookup and update of the same index: lookup sees pre-update contents; the new contents are visible from the next cycle. No bypass.
- Aliasing: a different tag at the same index is a miss; only a taken update evicts the entry.
- Latency:
  - Prediction: 0 cycles (same cycle as pc).
  - Redirect: 1 cycle (pc equals redirect_pc the cycle after redirect_valid).
- Implementation: storage in flops (BTB_DEPTH x (1 + tag + XLEN + 2) bits); no memory macros.

Test Plan:
- Reset then free-run, stall=0, no updates: pc = 0x0, 0x4, 0x8, 0xC; pred_taken=0 throughout.
- stall=1 for 3 cycles at pc=0x10: pc stays 0x10. Then redirect_valid=1, redirect_pc=0x200 with stall=1: next cycle pc=0x200.
- Training:
  - upd_valid, upd_pc=0x40, taken, target 0x100, BTB_DEPTH=16. Redirect to 0x40: pc=0x40 gives pred_taken=1, pred_target=0x100; next pc=0x100.
  - Two not-taken updates for 0x40 (ctr 10->01->00): fetch at 0x40 gives pred_taken=0, next pc=0x44.
- Saturation: four taken updates for 0x80, then one not-taken (ctr 11->10): still predicts taken.
- Aliasing: entry for 0x40 trained taken; fetch 0x440 (same idx, different tag): pred_taken=0. Then a taken update at 0x440 -> 0x500 evicts it, and fetch 0x40 gives pred_taken=0.
- Wrap and same-cycle update:
  - Redirect to 32'hFFFF_FFFC: next pc=0x0.
  - Update at pc's own index in the same cycle as its fetch: pred_taken reflects old contents that cycle, new contents the next.
